eth_reg_master: RTL and testbench
=================================

# eth_reg_master

Register-port initiator: it drives the same write/read request port that the Ethernet transport's configuration registers respond on. It accepts a command stream (write or read, address, data), issues single-cycle write or read requests, and waits for the read response under a bounded timeout. It returns one response per command on a valid/ready channel. It sits between the control processor's command path and the transport's MAC/IP/UDP/bridge register bank.

## Interface
Parameters:
- REG_AWIDTH, 14, register address width; must match the responder.
- TIMEOUT, 15, maximum cycles to wait for a read response after the request cycle; legal range ≥1.
- ERR_DATA, 32'hFFFF_FFFF, value returned in rsp_data on timeout.

Ports:
- clk  in  1  sole clock.
- reset_n  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted when high with cmd_valid.
- cmd_wr  in  1  1 = write, 0 = read.
- cmd_addr  in  REG_AWIDTH  register address.
- cmd_data  in  32  write data; ignored for reads.
- reg_wr_req  out  1  one-cycle write strobe.
- reg_wr_addr  out  REG_AWIDTH  write address.
- reg_wr_data  out  32  write data.
- reg_rd_req  out  1  one-cycle read strobe.
- reg_rd_addr  out  REG_AWIDTH  read address.
- reg_rd_resp  in  1  read response strobe.
- reg_rd_data  in  32  read data; valid with reg_rd_resp.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  response consumed.
- rsp_data  out  32  read data, 0 for writes, ERR_DATA on timeout.
- rsp_err  out  1  1 = read timed out.
- stat_wr_cnt, stat_rd_cnt, stat_to_cnt  out  16 each  statistics counters (see Configuration).

## Operation
- States: IDLE, WR, RD_WAIT, RSP.
- cmd_ready is high only in IDLE; exactly one command is outstanding.
- IDLE accepting a write goes to WR, with address/data registered.
- IDLE accepting a read goes to RD_WAIT, with address registered and reg_rd_req pulsed.
- WR:
  - reg_wr_req is high for exactly one cycle.
  - Then go to RSP with rsp_data=0, rsp_err=0.
- RD_WAIT:
  - Counter loads 0 on entry and increments each cycle.
  - reg_rd_resp is sampled only in this state.
  - On reg_rd_resp, capture reg_rd_data and go to RSP with rsp_err=0.
  - If count reaches TIMEOUT without a response, go to RSP with rsp_data=ERR_DATA, rsp_err=1.
  - A response arriving in the same cycle the count reaches TIMEOUT wins over the timeout.
- RSP:
  - rsp_valid is held, with rsp_data/rsp_err stable, until rsp_ready.
  - Then return to IDLE.
- reg_rd_resp outside RD_WAIT (late or spurious) is ignored and does not affect state or counters.
- reg_wr_addr/reg_wr_data/reg_rd_addr hold their last values when strobes are low.
- Counter width is $clog2(TIMEOUT+1).
- Reset, asynchronous, any state:
  - state returns to IDLE;
  - all outputs are 0, including cmd_ready; cmd_ready rises the first cycle after reset_n deasserts;
  - the in-flight command is dropped with no response;
  - stat counters clear to 0.

## Timing
- Command accepted at cycle N.
- Write:
  - reg_wr_req high at N+1;
  - rsp_valid high at N+2;
  - earliest next accept at N+3 if rsp_ready is held high.
- Read:
  - reg_rd_req high at N+1;
  - responder one-cycle latency gives reg_rd_resp at N+2 and rsp_valid at N+3;
  - last accepted response cycle is N+1+TIMEOUT;
  - a timeout rsp_valid appears at N+2+TIMEOUT.
- All outputs are registered; no combinational path from cmd_* or rsp_ready to reg_* outputs.

## Configuration
- Macro ETH_REG_MASTER_STATS_EN.
- Defined:
  - stat_wr_cnt increments on each WR strobe;
  - stat_rd_cnt increments on each successful read;
  - stat_to_cnt increments on each timeout;
  - all counters saturate at 16'hFFFF.
- Undefined: the three stat ports are tied to 0 and no counter logic is built.

## Structure
- Package eth_reg_master_pkg holds:
  - the state enum (IDLE, WR, RD_WAIT, RSP);
  - the default ERR_DATA constant;
  - the stat counter width localparam (16).
- One sub-module, eth_reg_stat_cnt: a saturating 16-bit counter with increment and async active-low clear, instantiated three times under the macro.

## Test plan
- Write 0x1000 ← 0xC0A8_010A: reg_wr_req one cycle at N+1 with matching addr/data; rsp_valid at N+2, rsp_data=0, rsp_err=0.
- Read 0x1004, responder replies next cycle with 0x0000_C001: rsp_valid at N+3, rsp_data=0x0000_C001, rsp_err=0.
- Read with responder silent, TIMEOUT=15: rsp_valid at N+17, rsp_data=0xFFFF_FFFF, rsp_err=1; a reg_rd_resp injected at N+20 is ignored.
- Read answered exactly at N+16 (the count reaches TIMEOUT that cycle): response wins, rsp_err=0; same stimulus with the answer at N+17 gives a timeout.
- rsp_ready held low 10 cycles after a read: rsp_valid/rsp_data stable, cmd_ready low throughout; next command accepted the cycle after rsp_ready.
- With ETH_REG_MASTER_STATS_EN: reset_n pulsed low during RD_WAIT leaves all outputs 0 and no response; after 2 writes, 1 read, 1 timeout, counters read 2/1/1.

Source files
------------

// File: rtl/eth_reg_master_pkg.sv
// Shared types and constants for the register-port initiator and its statistics counters.
package eth_reg_master_pkg;

   typedef enum logic [1:0] {
      IDLE,
      WR,
      RD_WAIT,
      RSP
   } state_t;

   localparam logic [31:0] ERR_DATA_DEFAULT = 32'hFFFF_FFFF;
   localparam int          STAT_W           = 16;

endpackage

// File: rtl/eth_reg_stat_cnt.sv
// Saturating statistics counter with increment strobe and asynchronous active-low clear.
module eth_reg_stat_cnt
   import eth_reg_master_pkg::*;
(
   input  logic              clk,
   input  logic              reset_n,
   input  logic              inc,
   output logic [STAT_W-1:0] cnt
);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt <= '0;
      end else if (inc && (cnt != '1)) begin
         cnt <= cnt + STAT_W'(1);
      end
   end

endmodule

// File: rtl/eth_reg_master.sv
// Register-port initiator: one command in flight, single-cycle write/read strobes, bounded read wait.
// Optional statistics counters are built only when ETH_REG_MASTER_STATS_EN is defined.
module eth_reg_master
   import eth_reg_master_pkg::*;
#(
   parameter int          REG_AWIDTH = 14,
   parameter int          TIMEOUT    = 15,
   parameter logic [31:0] ERR_DATA   = ERR_DATA_DEFAULT
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic                  cmd_wr,
   input  logic [REG_AWIDTH-1:0] cmd_addr,
   input  logic [31:0]           cmd_data,
   output logic                  reg_wr_req,
   output logic [REG_AWIDTH-1:0] reg_wr_addr,
   output logic [31:0]           reg_wr_data,
   output logic                  reg_rd_req,
   output logic [REG_AWIDTH-1:0] reg_rd_addr,
   input  logic                  reg_rd_resp,
   input  logic [31:0]           reg_rd_data,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [31:0]           rsp_data,
   output logic                  rsp_err,
   output logic [STAT_W-1:0]     stat_wr_cnt,
   output logic [STAT_W-1:0]     stat_rd_cnt,
   output logic [STAT_W-1:0]     stat_to_cnt
);

   localparam int               CNT_W   = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT);

   state_t           state;
   state_t           state_next;
   logic [CNT_W-1:0] cnt;
   logic             accept;
   logic             rd_hit;
   logic             rd_to;

   assign accept = cmd_valid && cmd_ready;
   // A response in the final wait cycle wins over the timeout.
   assign rd_hit = (state == RD_WAIT) && reg_rd_resp;
   assign rd_to  = (state == RD_WAIT) && !reg_rd_resp && (cnt == TO_LAST);

   // NOTE: state_next gets its default before the case so no path leaves it unassigned (no latch).
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (accept) state_next = cmd_wr ? WR : RD_WAIT;
         WR:      state_next = RSP;
         RD_WAIT: if (rd_hit || rd_to) state_next = RSP;
         RSP:     if (rsp_ready) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Strobes and handshakes are decoded from state_next so every output leaves a flop.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state       <= IDLE;
         cmd_ready   <= 1'b0;
         reg_wr_req  <= 1'b0;
         reg_wr_addr <= '0;
         reg_wr_data <= '0;
         reg_rd_req  <= 1'b0;
         reg_rd_addr <= '0;
         rsp_valid   <= 1'b0;
         rsp_data    <= '0;
         rsp_err     <= 1'b0;
         cnt         <= '0;
      end else begin
         // NOTE: non-blocking assignments keep every flop reading pre-edge values.
         state      <= state_next;
         cmd_ready  <= (state_next == IDLE);
         reg_wr_req <= (state_next == WR);
         reg_rd_req <= (state == IDLE) && (state_next == RD_WAIT);
         rsp_valid  <= (state_next == RSP);

         if (accept) begin
            cnt <= '0;
            if (cmd_wr) begin
               reg_wr_addr <= cmd_addr;
               reg_wr_data <= cmd_data;
            end else begin
               reg_rd_addr <= cmd_addr;
            end
         end else if (state == RD_WAIT) begin
            cnt <= cnt + CNT_W'(1);
         end

         if (state == WR) begin
            rsp_data <= '0;
            rsp_err  <= 1'b0;
         end else if (rd_hit) begin
            rsp_data <= reg_rd_data;
            rsp_err  <= 1'b0;
         end else if (rd_to) begin
            rsp_data <= ERR_DATA;
            rsp_err  <= 1'b1;
         end
      end
   end

`ifdef ETH_REG_MASTER_STATS_EN
   eth_reg_stat_cnt u_wr_cnt (.clk(clk), .reset_n(reset_n), .inc(reg_wr_req), .cnt(stat_wr_cnt));
   eth_reg_stat_cnt u_rd_cnt (.clk(clk), .reset_n(reset_n), .inc(rd_hit),     .cnt(stat_rd_cnt));
   eth_reg_stat_cnt u_to_cnt (.clk(clk), .reset_n(reset_n), .inc(rd_to),      .cnt(stat_to_cnt));
`else
   assign stat_wr_cnt = '0;
   assign stat_rd_cnt = '0;
   assign stat_to_cnt = '0;
`endif

endmodule

// File: tb/tb_eth_reg_master.sv
// Directed self-checking bench for eth_reg_master (default parameters, TIMEOUT=15).
module tb_eth_reg_master;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic        cmd_wr = 1'b0;
   logic [13:0] cmd_addr = '0;
   logic [31:0] cmd_data = '0;
   logic        reg_wr_req;
   logic [13:0] reg_wr_addr;
   logic [31:0] reg_wr_data;
   logic        reg_rd_req;
   logic [13:0] reg_rd_addr;
   logic        reg_rd_resp = 1'b0;
   logic [31:0] reg_rd_data = '0;
   logic        rsp_valid;
   logic        rsp_ready = 1'b0;
   logic [31:0] rsp_data;
   logic        rsp_err;
   logic [15:0] stat_wr_cnt;
   logic [15:0] stat_rd_cnt;
   logic [15:0] stat_to_cnt;

   int n_checks = 0;
   int n_fail   = 0;

   eth_reg_master dut (
      .clk(clk), .reset_n(reset_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr(cmd_wr),
      .cmd_addr(cmd_addr), .cmd_data(cmd_data),
      .reg_wr_req(reg_wr_req), .reg_wr_addr(reg_wr_addr), .reg_wr_data(reg_wr_data),
      .reg_rd_req(reg_rd_req), .reg_rd_addr(reg_rd_addr),
      .reg_rd_resp(reg_rd_resp), .reg_rd_data(reg_rd_data),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
      .stat_wr_cnt(stat_wr_cnt), .stat_rd_cnt(stat_rd_cnt), .stat_to_cnt(stat_to_cnt)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running at %0t, expected completion earlier", $time);
      $fatal(1, "watchdog expired");
   end

   // Every task stays aligned 1 time unit after a rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Present a command and return in the cycle after it is accepted (cycle N+1).
   task automatic issue(input logic wr, input logic [13:0] a, input logic [31:0] d);
      int k = 0;
      cmd_valid = 1'b1; cmd_wr = wr; cmd_addr = a; cmd_data = d;
      while (!cmd_ready && k < 40) begin
         step();
         k++;
      end
      if (cmd_ready !== 1'b1) begin
         $display("FAIL issue_ready: cmd_ready=%b, expected 1 within 40 cycles", cmd_ready);
         n_fail++;
      end
      n_checks++;
      step();
      cmd_valid = 1'b0;
   endtask

   // Wait (bounded) for rsp_valid, then consume it with rsp_ready held high.
   task automatic wait_rsp();
      int k = 0;
      while (!rsp_valid && k < 40) begin
         step();
         k++;
      end
      if (rsp_valid !== 1'b1) begin
         $display("FAIL wait_rsp: rsp_valid=%b, expected 1 within 40 cycles", rsp_valid);
         n_fail++;
      end
      n_checks++;
      step();
   endtask

   task automatic test_reset();
      repeat (3) step();
      if ({cmd_ready, reg_wr_req, reg_rd_req, rsp_valid, rsp_err} !== 5'b0) begin
         $display("FAIL reset_ctrl: got %b, expected 00000", {cmd_ready, reg_wr_req, reg_rd_req, rsp_valid, rsp_err});
         n_fail++;
      end
      n_checks++;
      if (rsp_data !== 32'h0) begin
         $display("FAIL reset_rsp_data: got %h, expected 00000000", rsp_data);
         n_fail++;
      end
      n_checks++;
      reset_n = 1'b1;
      #1;
      if (cmd_ready !== 1'b0) begin
         $display("FAIL reset_release_ready: got %b, expected 0", cmd_ready);
         n_fail++;
      end
      n_checks++;
      step();
      if (cmd_ready !== 1'b1) begin
         $display("FAIL reset_first_ready: got %b, expected 1", cmd_ready);
         n_fail++;
      end
      n_checks++;
   endtask

   task automatic test_write();
      rsp_ready = 1'b1;
      issue(1'b1, 14'h1000, 32'hC0A8_010A);
      if ({reg_wr_req, reg_rd_req, rsp_valid, cmd_ready} !== 4'b1000) begin
         $display("FAIL wr_n1_ctrl: got %b, expected 1000", {reg_wr_req, reg_rd_req, rsp_valid, cmd_ready});
         n_fail++;
      end
      n_checks++;
      if (reg_wr_addr !== 14'h1000 || reg_wr_data !== 32'hC0A8_010A) begin
         $display("FAIL wr_n1_addr_data: got %h/%h, expected 1000/c0a8010a", reg_wr_addr, reg_wr_data);
         n_fail++;
      end
      n_checks++;
      step();
      if ({reg_wr_req, rsp_valid, rsp_err} !== 3'b010 || rsp_data !== 32'h0) begin
         $display("FAIL wr_n2_rsp: req/valid/err=%b data=%h, expected 010 data=00000000",
                  {reg_wr_req, rsp_valid, rsp_err}, rsp_data);
         n_fail++;
      end
      n_checks++;
      if (reg_wr_addr !== 14'h1000 || reg_wr_data !== 32'hC0A8_010A) begin
         $display("FAIL wr_n2_hold: got %h/%h, expected 1000/c0a8010a", reg_wr_addr, reg_wr_data);
         n_fail++;
      end
      n_checks++;
      step();
      if ({cmd_ready, rsp_valid} !== 2'b10) begin
         $display("FAIL wr_n3_ready: ready/valid=%b, expected 10", {cmd_ready, rsp_valid});
         n_fail++;
      end
      n_checks++;
   endtask

   task automatic test_read();
      rsp_ready = 1'b1;
      issue(1'b0, 14'h1004, 32'h0);
      if (reg_rd_req !== 1'b1 || reg_rd_addr !== 14'h1004 || reg_wr_req !== 1'b0) begin
         $display("FAIL rd_n1_req: rd_req=%b addr=%h wr_req=%b, expected 1/1004/0", reg_rd_req, reg_rd_addr, reg_wr_req);
         n_fail++;
      end
      n_checks++;
      step();
      if ({reg_rd_req, rsp_valid} !== 2'b00) begin
         $display("FAIL rd_n2: rd_req/valid=%b, expected 00", {reg_rd_req, rsp_valid});
         n_fail++;
      end
      n_checks++;
      reg_rd_resp = 1'b1; reg_rd_data = 32'h0000_C001;
      step();
      reg_rd_resp = 1'b0; reg_rd_data = 32'h0;
      if (rsp_valid !== 1'b1 || rsp_data !== 32'h0000_C001 || rsp_err !== 1'b0) begin
         $display("FAIL rd_n3_rsp: valid=%b data=%h err=%b, expected 1/0000c001/0", rsp_valid, rsp_data, rsp_err);
         n_fail++;
      end
      n_checks++;
      step();
   endtask

   task automatic test_timeout();
      int early = 0;
      rsp_ready = 1'b1;
      issue(1'b0, 14'h2000, 32'h0);
      for (int k = 2; k <= 16; k++) begin
         step();
         if (rsp_valid !== 1'b0) early++;
      end
      if (early != 0) begin
         $display("FAIL to_early: rsp_valid high in %0d of cycles N+2..N+16, expected 0", early);
         n_fail++;
      end
      n_checks++;
      step();
      if (rsp_valid !== 1'b1 || rsp_data !== 32'hFFFF_FFFF || rsp_err !== 1'b1) begin
         $display("FAIL to_n17_rsp: valid=%b data=%h err=%b, expected 1/ffffffff/1", rsp_valid, rsp_data, rsp_err);
         n_fail++;
      end
      n_checks++;
      repeat (3) step();
      reg_rd_resp = 1'b1; reg_rd_data = 32'h1234_5678;
      step();
      reg_rd_resp = 1'b0; reg_rd_data = 32'h0;
      if ({cmd_ready, rsp_valid} !== 2'b10 || rsp_data !== 32'hFFFF_FFFF) begin
         $display("FAIL to_late_resp: ready/valid=%b data=%h, expected 10/ffffffff", {cmd_ready, rsp_valid}, rsp_data);
         n_fail++;
      end
      n_checks++;
   endtask

   task automatic test_boundary();
      rsp_ready = 1'b1;
      issue(1'b0, 14'h0010, 32'h0);
      repeat (15) step();
      reg_rd_resp = 1'b1; reg_rd_data = 32'hB0B0_0016;
      step();
      reg_rd_resp = 1'b0; reg_rd_data = 32'h0;
      if (rsp_valid !== 1'b1 || rsp_data !== 32'hB0B0_0016 || rsp_err !== 1'b0) begin
         $display("FAIL edge_n16_wins: valid=%b data=%h err=%b, expected 1/b0b00016/0", rsp_valid, rsp_data, rsp_err);
         n_fail++;
      end
      n_checks++;
      step();
      issue(1'b0, 14'h0010, 32'h0);
      repeat (16) step();
      reg_rd_resp = 1'b1; reg_rd_data = 32'hB0B0_0017;
      if (rsp_valid !== 1'b1 || rsp_data !== 32'hFFFF_FFFF || rsp_err !== 1'b1) begin
         $display("FAIL edge_n17_timeout: valid=%b data=%h err=%b, expected 1/ffffffff/1", rsp_valid, rsp_data, rsp_err);
         n_fail++;
      end
      n_checks++;
      step();
      reg_rd_resp = 1'b0; reg_rd_data = 32'h0;
      if ({cmd_ready, rsp_valid} !== 2'b10 || rsp_data !== 32'hFFFF_FFFF) begin
         $display("FAIL edge_n18_idle: ready/valid=%b data=%h, expected 10/ffffffff", {cmd_ready, rsp_valid}, rsp_data);
         n_fail++;
      end
      n_checks++;
   endtask

   task automatic test_backpressure();
      int bad = 0;
      rsp_ready = 1'b0;
      issue(1'b0, 14'h0040, 32'h0);
      step();
      reg_rd_resp = 1'b1; reg_rd_data = 32'hDEAD_BEEF;
      step();
      reg_rd_resp = 1'b0; reg_rd_data = 32'h0;
      cmd_valid = 1'b1; cmd_wr = 1'b1; cmd_addr = 14'h0044; cmd_data = 32'h0000_0055;
      for (int i = 0; i < 10; i++) begin
         if (rsp_valid !== 1'b1 || rsp_data !== 32'hDEAD_BEEF || rsp_err !== 1'b0 ||
             cmd_ready !== 1'b0 || reg_wr_req !== 1'b0) bad++;
         step();
      end
      if (bad != 0) begin
         $display("FAIL bp_stall: %0d of 10 stalled cycles not stable, expected 0", bad);
         n_fail++;
      end
      n_checks++;
      rsp_ready = 1'b1;
      if (rsp_valid !== 1'b1 || cmd_ready !== 1'b0) begin
         $display("FAIL bp_release: valid/ready=%b%b, expected 10", rsp_valid, cmd_ready);
         n_fail++;
      end
      n_checks++;
      step();
      if ({cmd_ready, rsp_valid} !== 2'b10) begin
         $display("FAIL bp_idle: ready/valid=%b, expected 10", {cmd_ready, rsp_valid});
         n_fail++;
      end
      n_checks++;
      step();
      cmd_valid = 1'b0;
      if (reg_wr_req !== 1'b1 || reg_wr_addr !== 14'h0044 || reg_wr_data !== 32'h0000_0055) begin
         $display("FAIL bp_next_cmd: req=%b addr=%h data=%h, expected 1/0044/00000055", reg_wr_req, reg_wr_addr, reg_wr_data);
         n_fail++;
      end
      n_checks++;
      step();
      if (rsp_valid !== 1'b1 || rsp_data !== 32'h0) begin
         $display("FAIL bp_wr_rsp: valid=%b data=%h, expected 1/00000000", rsp_valid, rsp_data);
         n_fail++;
      end
      n_checks++;
      step();
   endtask

   task automatic test_reset_in_rd_wait();
      int bad = 0;
      rsp_ready = 1'b1;
      issue(1'b0, 14'h0100, 32'h0);
      step();
      reset_n = 1'b0;
      #1;
      if ({cmd_ready, reg_wr_req, reg_rd_req, rsp_valid, rsp_err} !== 5'b0 ||
          rsp_data !== 32'h0 || reg_rd_addr !== 14'h0 || reg_wr_addr !== 14'h0 || reg_wr_data !== 32'h0) begin
         $display("FAIL rst_rd_outputs: ctrl=%b data=%h rd_addr=%h wr=%h/%h, expected all 0",
                  {cmd_ready, reg_wr_req, reg_rd_req, rsp_valid, rsp_err}, rsp_data, reg_rd_addr, reg_wr_addr, reg_wr_data);
         n_fail++;
      end
      n_checks++;
      if ({stat_wr_cnt, stat_rd_cnt, stat_to_cnt} !== 48'h0) begin
         $display("FAIL rst_rd_stats: got %h/%h/%h, expected 0/0/0", stat_wr_cnt, stat_rd_cnt, stat_to_cnt);
         n_fail++;
      end
      n_checks++;
      repeat (2) step();
      reset_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         step();
         if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) bad++;
      end
      if (bad != 0) begin
         $display("FAIL rst_rd_dropped: %0d of 6 cycles with response or not ready, expected 0", bad);
         n_fail++;
      end
      n_checks++;
   endtask

   task automatic test_stats();
      rsp_ready = 1'b1;
      issue(1'b1, 14'h0200, 32'h1111_1111);
      wait_rsp();
      issue(1'b1, 14'h0204, 32'h2222_2222);
      wait_rsp();
      issue(1'b0, 14'h0208, 32'h0);
      reg_rd_resp = 1'b1; reg_rd_data = 32'h3333_3333;
      step();
      reg_rd_resp = 1'b0;
      wait_rsp();
      issue(1'b0, 14'h020C, 32'h0);
      wait_rsp();
      reg_rd_resp = 1'b1;
      step();
      reg_rd_resp = 1'b0;
      step();
`ifdef ETH_REG_MASTER_STATS_EN
      if (stat_wr_cnt !== 16'd2 || stat_rd_cnt !== 16'd1 || stat_to_cnt !== 16'd1) begin
         $display("FAIL stats_counts: got %0d/%0d/%0d, expected 2/1/1", stat_wr_cnt, stat_rd_cnt, stat_to_cnt);
         n_fail++;
      end
`else
      if (stat_wr_cnt !== 16'd0 || stat_rd_cnt !== 16'd0 || stat_to_cnt !== 16'd0) begin
         $display("FAIL stats_tied: got %0d/%0d/%0d, expected 0/0/0", stat_wr_cnt, stat_rd_cnt, stat_to_cnt);
         n_fail++;
      end
`endif
      n_checks++;
   endtask

   initial begin
      test_reset();
      test_write();
      test_read();
      test_timeout();
      test_boundary();
      test_backpressure();
      test_reset_in_rd_wait();
      test_stats();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
